alu_rr_scheduler: RTL and testbench

- Two-requester, round-robin scheduler wrapped around the team's registered ALU datapath.
- Opcodes: ADD, SUB, AND, OR, SLL, SGT, PASSB, SLT, plus a carry flag.
- Each requester issues one operation through a valid/ready handshake. The block arbitrates, captures operands, executes, and returns the tagged result through a valid/ready response channel with backpressure.
- Sits between the instruction-issue logic and the shared ALU, so one ALU serves two sources.

---
 rtl/alu_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for a single registered ALU.
// Flow: IDLE (arbitrate + capture) -> EXEC (compute, register) -> RESP (hold until accepted).
module alu_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req0_opcode,
  input  logic [3:0]         req1_opcode,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [SHIFT_W-1:0] req0_shamt,
  input  logic [SHIFT_W-1:0] req1_shamt,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_carry,
  output logic               resp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             r_state, w_next;
  logic               r_last_grant;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [SHIFT_W-1:0] r_shamt;
  logic               r_id;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry, r_illegal;

  logic               w_any, w_grant, w_hs;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry, w_illegal;

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign w_any   = |req_valid;
  assign w_grant = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_hs    = (r_state == IDLE) && w_any;

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    case (r_state)
      IDLE: if (w_any) begin
        req_ready = w_grant ? 2'b10 : 2'b01;
        w_next    = EXEC;
      end
      EXEC: w_next = RESP;
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_shamt      <= '0;
      r_id         <= 1'b0;
    end else if (w_hs) begin
      r_last_grant <= w_grant;
      r_id         <= w_grant;
      r_op         <= w_grant ? req1_opcode : req0_opcode;
      r_a          <= w_grant ? req1_a      : req0_a;
      r_b          <= w_grant ? req1_b      : req0_b;
      r_shamt      <= w_grant ? req1_shamt  : req0_shamt;
    end
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    case (r_op)
      4'd0: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      4'd1: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      4'd2: w_res = r_a & r_b;
      4'd3: w_res = r_a | r_b;
      4'd4: w_res = r_a << r_shamt;
      4'd5: w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) > $signed(r_b))};
      4'd6: w_res = r_b;
      4'd7: w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result  <= w_res;
      r_carry   <= w_carry;
      r_illegal <= w_illegal;
    end
  end

  assign resp_valid   = (r_state == RESP);
  assign resp_id      = r_id;
  assign resp_result  = r_result;
  assign resp_carry   = r_carry;
  assign resp_illegal = r_illegal;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: opcodes, arbitration order, backpressure, reset abort.
module tb_alu_rr_scheduler;
  logic        clk = 0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        resp_valid, resp_ready, resp_id, resp_carry, resp_illegal;
  logic [31:0] resp_result;

  int total = 0;
  int bad   = 0;

  alu_rr_scheduler #(.WIDTH(32), .SHIFT_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    if (r == 0) begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_shamt = sh;
    end else begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_shamt = sh;
    end
  endtask

  // One lone-requester op with resp_ready high: handshake, EXEC, RESP on successive negedges.
  task automatic do_op(input string tag, input int r, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] er, input logic ec, input logic ei);
    @(negedge clk);
    set_req(r, op, a, b, sh);
    req_valid = (r == 0) ? 2'b01 : 2'b10;
    #1 chk({tag, ".ready"}, req_ready, req_valid);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk({tag, ".exec_vld"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, ".vld"}, resp_valid, 1);
    chk({tag, ".id"}, resp_id, r[0]);
    chk({tag, ".res"}, resp_result, er);
    chk({tag, ".carry"}, resp_carry, ec);
    chk({tag, ".ill"}, resp_illegal, ei);
  endtask

  initial begin
    reset = 1; req_valid = 0; resp_ready = 1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.vld", resp_valid, 0);
    chk("rst.ready", req_ready, 0);
    chk("rst.res", resp_result, 0);
    chk("rst.id", resp_id, 0);
    reset = 0;

    do_op("add",   0, 4'd0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0);
    do_op("sub",   1, 4'd1, 32'd3, 32'd5, 0, 32'hFFFF_FFFE, 1, 0);
    do_op("slt",   0, 4'd7, 32'h8000_0000, 32'h1, 0, 32'h1, 0, 0);
    do_op("sgt",   0, 4'd5, 32'h8000_0000, 32'h1, 0, 32'h0, 0, 0);
    do_op("sll",   1, 4'd4, 32'h1, 32'h0, 5'd31, 32'h8000_0000, 0, 0);
    do_op("passb", 0, 4'd6, 32'hDEAD, 32'h1234, 0, 32'h1234, 0, 0);
    do_op("and",   1, 4'd2, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0);
    do_op("or",    0, 4'd3, 32'hF0, 32'h0F, 0, 32'hFF, 0, 0);
    do_op("ill",   1, 4'd9, 32'h7, 32'h7, 0, 32'h0, 0, 1);

    // Backpressure: req1 result held while req0 waits.
    @(negedge clk);
    resp_ready = 0;
    set_req(1, 4'd6, 0, 32'h55, 0);
    req_valid = 2'b10;
    #1 chk("bp.ready", req_ready, 2'b10);
    @(negedge clk);
    set_req(0, 4'd2, 32'hFF, 32'h0F, 0);
    req_valid = 2'b01;
    chk("bp.exec_ready", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.vld", resp_valid, 1);
      chk("bp.res", resp_result, 32'h55);
      chk("bp.id", resp_id, 1);
      chk("bp.ready_hold", req_ready, 0);
    end
    resp_ready = 1;
    @(negedge clk);
    chk("bp.rel_vld", resp_valid, 0);
    chk("bp.rel_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp.next_res", resp_result, 32'h0F);
    chk("bp.next_id", resp_id, 0);

    // Reset during EXEC aborts the op.
    @(negedge clk);
    set_req(0, 4'd0, 32'd5, 32'd6, 0);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("rx.vld", resp_valid, 0);
    chk("rx.res", resp_result, 0);
    chk("rx.id", resp_id, 0);
    chk("rx.carry", resp_carry, 0);
    chk("rx.ill", resp_illegal, 0);
    chk("rx.ready", req_ready, 0);
    reset = 0;
    @(negedge clk);
    chk("rx.no_resp", resp_valid, 0);

    // Continuous contention: strict alternation starting at requester 0.
    set_req(0, 4'd0, 32'd1, 32'd1, 0);
    set_req(1, 4'd3, 32'hF0, 32'h0F, 0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr.ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("rr.exec_ready", req_ready, 0);
      @(negedge clk);
      chk("rr.vld", resp_valid, 1);
      chk("rr.id", resp_id, k % 2);
      chk("rr.res", resp_result, (k % 2) ? 32'hFF : 32'h2);
      @(negedge clk);
      chk("rr.idle_vld", resp_valid, 0);
    end
    req_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
